// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle for chunked_serial_adder.
// master = producer/consumer side, slave = the adder.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple slice per clock with a
// registered carry, producing WIDTH-bit sum, carry-out and signed overflow.

module csa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);
  logic [CHUNK:0] r;

  assign r    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign s    = r[CHUNK-1:0];
  assign co   = r[CHUNK];
  // carry into the top bit falls out of that bit's own sum
  assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
endmodule

module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  chunked_serial_adder_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                  state;
  logic [IW-1:0]               idx;
  logic                        carry;
  logic [NCH-1:0][CHUNK-1:0]   a_q, b_q, sum_q, sum_nxt;
  logic                        cout_q, ovf_q;
  logic [CHUNK-1:0]            ca, cb, cs;
  logic                        cco, ccm;

  generate
    if (NCH == 1) begin : g_one
      assign ca = a_q[0];
      assign cb = b_q[0];
      always_comb sum_nxt = cs;
    end else begin : g_multi
      assign ca = a_q[idx];
      assign cb = b_q[idx];
      always_comb begin
        sum_nxt      = sum_q;
        sum_nxt[idx] = cs;
      end
    end
  endgenerate

  csa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (ca),
    .b    (cb),
    .ci   (carry),
    .s    (cs),
    .co   (cco),
    .cmsb (ccm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          // subtract folds into add: invert B and force carry-in to 1
          a_q   <= bus.a;
          b_q   <= bus.sub ? ~bus.b : bus.b;
          carry <= bus.sub | bus.cin;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          sum_q <= sum_nxt;
          carry <= cco;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q <= cco;
            ovf_q  <= ccm ^ cco;
            state  <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed checks of chunked_serial_adder at 32/4, plus lockstep random
// comparison of 8/8 and 8/2 instances against an arithmetic reference.
`timescale 1ns/1ps
module tb_chunked_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  chunked_serial_adder_if #(.WIDTH(32)) bus32 ();
  chunked_serial_adder_if #(.WIDTH(8))  bus88 ();
  chunked_serial_adder_if #(.WIDTH(8))  bus82 ();

  chunked_serial_adder #(.WIDTH(32), .CHUNK(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  chunked_serial_adder #(.WIDTH(8),  .CHUNK(8)) dut88 (.clk(clk), .rst(rst), .bus(bus88));
  chunked_serial_adder #(.WIDTH(8),  .CHUNK(2)) dut82 (.clk(clk), .rst(rst), .bus(bus82));

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic, input logic is);
    @(negedge clk);
    bus32.a = ia; bus32.b = ib; bus32.cin = ic; bus32.sub = is;
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus32.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready); end
    checks++; if (bus32.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus32.out_valid); end
    checks++; if ({bus32.sum, bus32.cout, bus32.ovf} !== 34'h0) begin fails++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b want 0", bus32.sum, bus32.cout, bus32.ovf); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus32.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", bus32.in_ready); end
  endtask

  task automatic test_add();
    int lat;
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL add_latency: got %0d want 8", lat); end
    checks++; if (bus32.sum !== 32'h0000_0100) begin fails++; $display("FAIL add_sum: got %h want 00000100", bus32.sum); end
    checks++; if ({bus32.cout, bus32.ovf} !== 2'b00) begin fails++; $display("FAIL add_flags: got %b%b want 00", bus32.cout, bus32.ovf); end
    retire();
    checks++; if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin fails++; $display("FAIL add_retire: got valid/ready %b%b want 01", bus32.out_valid, bus32.in_ready); end
  endtask

  task automatic test_carry_ovf();
    int lat;
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    wait_done(lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL wrap_latency: got %0d want 8", lat); end
    checks++; if ({bus32.sum, bus32.cout, bus32.ovf} !== {32'h0, 1'b1, 1'b0}) begin fails++; $display("FAIL wrap_result: got %h c=%b v=%b want 00000000 c=1 v=0", bus32.sum, bus32.cout, bus32.ovf); end
    retire();
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if ({bus32.sum, bus32.cout, bus32.ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin fails++; $display("FAIL posovf_result: got %h c=%b v=%b want 80000000 c=0 v=1", bus32.sum, bus32.cout, bus32.ovf); end
    retire();
  endtask

  task automatic test_sub();
    int lat;
    issue(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done(lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL sub_latency: got %0d want 8", lat); end
    checks++; if ({bus32.sum, bus32.cout, bus32.ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin fails++; $display("FAIL sub_borrow: got %h c=%b v=%b want fffffffe c=0 v=0", bus32.sum, bus32.cout, bus32.ovf); end
    retire();
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(lat);
    checks++; if ({bus32.sum, bus32.cout, bus32.ovf} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin fails++; $display("FAIL sub_negovf: got %h c=%b v=%b want 7fffffff c=1 v=1", bus32.sum, bus32.cout, bus32.ovf); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    bus32.a = 32'hDEAD_BEEF; bus32.b = 32'h0BAD_F00D; bus32.cin = 1'b1; bus32.sub = 1'b1;
    bus32.in_valid = 1'b1;
    wait_done(lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL bp_latency: got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus32.out_valid, bus32.in_ready} !== 2'b10) begin fails++; $display("FAIL bp_hold_hs[%0d]: got valid/ready %b%b want 10", i, bus32.out_valid, bus32.in_ready); end
      checks++; if ({bus32.sum, bus32.cout, bus32.ovf} !== {32'h2345_6789, 1'b0, 1'b0}) begin fails++; $display("FAIL bp_hold_result[%0d]: got %h c=%b v=%b want 23456789 c=0 v=0", i, bus32.sum, bus32.cout, bus32.ovf); end
    end
    @(negedge clk); bus32.in_valid = 1'b0;
    retire();
    @(posedge clk); #1;
    checks++; if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin fails++; $display("FAIL bp_no_queue: got valid/ready %b%b want 01", bus32.out_valid, bus32.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin fails++; $display("FAIL midrst_state: got valid/ready %b%b want 01", bus32.out_valid, bus32.in_ready); end
    checks++; if ({bus32.sum, bus32.cout, bus32.ovf} !== 34'h0) begin fails++; $display("FAIL midrst_sum: got %h c=%b v=%b want 0", bus32.sum, bus32.cout, bus32.ovf); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus32.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", bus32.in_ready); end
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL midrst_latency: got %0d want 8", lat); end
    checks++; if (bus32.sum !== 32'h2345_6789) begin fails++; $display("FAIL midrst_next_sum: got %h want 23456789", bus32.sum); end
    retire();
  endtask

  task automatic test_back_to_back();
    int t[$];
    int n, d;
    @(negedge clk);
    bus32.a = 32'd1; bus32.b = 32'd2; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    n = 0;
    while (t.size() < 2 && n < 60) begin
      if (bus32.in_ready) t.push_back(n);
      if (t.size() < 2) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    d = (t.size() == 2) ? t[1] - t[0] : -1;
    checks++; if (d !== 10) begin fails++; $display("FAIL b2b_interval: got %0d want 10", d); end
    n = 0;
    while (!bus32.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    bus32.out_ready = 1'b0;
    checks++; if (bus32.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_drain: got in_ready %b want 1", bus32.in_ready); end
  endtask

  task automatic test_sweep();
    logic [7:0] ra, rb, be;
    logic       rc, rs, ci, xv;
    logic [8:0] r;
    int         lat8, lat2, cyc;
    bit         d8, d2, h8, h2;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      be = rs ? ~rb : rb;
      ci = rs ? 1'b1 : rc;
      r  = {1'b0, ra} + {1'b0, be} + {8'd0, ci};
      xv = (ra[7] == be[7]) && (r[7] != ra[7]);
      @(negedge clk);
      checks++; if ({bus88.in_ready, bus82.in_ready} !== 2'b11) begin fails++; $display("FAIL sweep_ready[%0d]: got %b%b want 11", n, bus88.in_ready, bus82.in_ready); end
      bus88.a = ra; bus88.b = rb; bus88.cin = rc; bus88.sub = rs; bus88.in_valid = 1'b1;
      bus82.a = ra; bus82.b = rb; bus82.cin = rc; bus82.sub = rs; bus82.in_valid = 1'b1;
      @(posedge clk); #1;
      bus88.in_valid = 1'b0; bus82.in_valid = 1'b0;
      cyc = 0; lat8 = -1; lat2 = -1; d8 = 1'b0; d2 = 1'b0;
      while (!(d8 && d2) && cyc < 40) begin
        if (lat8 < 0 && bus88.out_valid) lat8 = cyc;
        if (lat2 < 0 && bus82.out_valid) lat2 = cyc;
        @(negedge clk);
        h8 = bus88.out_valid && !d8 && ($urandom_range(0, 1) == 1);
        h2 = bus82.out_valid && !d2 && ($urandom_range(0, 1) == 1);
        bus88.out_ready = h8; bus82.out_ready = h2;
        if (h8) begin
          checks++; if ({bus88.cout, bus88.sum, bus88.ovf} !== {r, xv}) begin fails++; $display("FAIL sweep88[%0d] a=%h b=%h cin=%b sub=%b: got c=%b s=%h v=%b want c=%b s=%h v=%b", n, ra, rb, rc, rs, bus88.cout, bus88.sum, bus88.ovf, r[8], r[7:0], xv); end
        end
        if (h2) begin
          checks++; if ({bus82.cout, bus82.sum, bus82.ovf} !== {r, xv}) begin fails++; $display("FAIL sweep82[%0d] a=%h b=%h cin=%b sub=%b: got c=%b s=%h v=%b want c=%b s=%h v=%b", n, ra, rb, rc, rs, bus82.cout, bus82.sum, bus82.ovf, r[8], r[7:0], xv); end
        end
        @(posedge clk); #1;
        cyc++;
        if (h8) d8 = 1'b1;
        if (h2) d2 = 1'b1;
      end
      bus88.out_ready = 1'b0; bus82.out_ready = 1'b0;
      checks++; if ({d8, d2} !== 2'b11) begin fails++; $display("FAIL sweep_timeout[%0d]: got done %b%b want 11", n, d8, d2); end
      checks++; if (lat8 !== 1) begin fails++; $display("FAIL sweep88_latency[%0d]: got %0d want 1", n, lat8); end
      checks++; if (lat2 !== 4) begin fails++; $display("FAIL sweep82_latency[%0d]: got %0d want 4", n, lat2); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b0;
    bus88.in_valid = 1'b0; bus88.a = '0; bus88.b = '0; bus88.cin = 1'b0; bus88.sub = 1'b0; bus88.out_ready = 1'b0;
    bus82.in_valid = 1'b0; bus82.a = '0; bus82.b = '0; bus82.cin = 1'b0; bus82.sub = 1'b0; bus82.out_ready = 1'b0;
    test_reset();
    test_add();
    test_carry_ovf();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
